// File: rtl/byte_demux8_reg_pkg.sv
// Shared definitions for the eight-lane byte register bank.
// Holds the lane count, default lane width, pointer width and the FSM state encoding.
// Optional feature macro used by the block: BYTE_DEMUX8_READBACK_EN.
package byte_demux8_reg_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/byte_demux8_reg_if.sv
// Valid/ready byte-write channel into the lane bank.
// Signals: in_valid, in_ready, in_data[DW], in_addr_en, in_addr[3].
// master = byte source, slave = byte_demux8_reg.
interface byte_demux8_reg_if
  import byte_demux8_reg_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_addr_en;
  logic [PTR_W-1:0] in_addr;

  modport master (
    output in_valid, in_data, in_addr_en, in_addr,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_addr_en, in_addr,
    output in_ready
  );

endinterface

// File: rtl/byte_demux8_reg_rb_mux.sv
// byte_demux8_rb_mux: 8:1 readback selector over the packed lane bus.
// Ports: lanes[8*DW] packed lane bus (lane k at bits DW*k +: DW),
//        sel[3] lane index, rb_data[DW] selected lane (combinational).
// Only instantiated when BYTE_DEMUX8_READBACK_EN is defined.
module byte_demux8_rb_mux
  import byte_demux8_reg_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic [LANES*DW-1:0] lanes,
  input  logic [PTR_W-1:0]    sel,
  output logic [DW-1:0]       rb_data
);

  always_comb begin
    rb_data = lanes[32'(sel) * DW +: DW];
  end

endmodule

// File: rtl/byte_demux8_reg.sv
// byte_demux8_reg: scatters a valid/ready byte stream into eight registered lanes,
// by auto-incrementing pointer or explicit lane address, and flags each full frame.
// Ports: clk, rst_n (async, active-low), src (byte_demux8_reg_if.slave),
//        frame_start (sync restart), o_bus[8*DW] registered lanes, wr_ptr[3],
//        frame_done (one-cycle pulse during DONE).
// With BYTE_DEMUX8_READBACK_EN defined: rb_sel[3] in, rb_data[DW] out (lane[rb_sel]).
module byte_demux8_reg
  import byte_demux8_reg_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  byte_demux8_reg_if.slave    src,
  input  logic                frame_start,
  output logic [LANES*DW-1:0] o_bus,
  output logic [PTR_W-1:0]    wr_ptr,
  output logic                frame_done
`ifdef BYTE_DEMUX8_READBACK_EN
  ,
  input  logic [PTR_W-1:0]    rb_sel,
  output logic [DW-1:0]       rb_data
`endif
);

  state_t        state;
  logic [DW-1:0] lane [LANES];

  // Ready drops combinationally for the DONE cycle, on restart and while in reset.
  assign src.in_ready = (state != DONE) && !frame_start && rst_n;

  // Control FSM, pointer and lane registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      frame_done <= 1'b0;
      for (int k = 0; k < int'(LANES); k++) begin
        lane[k] <= '0;
      end
    end else if (frame_start) begin
      // Restart keeps lane contents; only control state is cleared.
      state      <= IDLE;
      wr_ptr     <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE, FILL: begin
          frame_done <= 1'b0;
          if (src.in_valid) begin
            if (src.in_addr_en) begin
              lane[src.in_addr] <= src.in_data;
            end else begin
              lane[wr_ptr] <= src.in_data;
              // Pointer wraps 7 -> 0 on the same edge that enters DONE.
              wr_ptr <= wr_ptr + PTR_W'(1);
              if (wr_ptr == PTR_W'(LANES - 1)) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                state <= FILL;
              end
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          wr_ptr     <= '0;
          frame_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          wr_ptr     <= '0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Lane k occupies bits [DW*k +: DW] of the output bus.
  for (genvar k = 0; k < int'(LANES); k++) begin : g_pack
    assign o_bus[k*DW +: DW] = lane[k];
  end

`ifdef BYTE_DEMUX8_READBACK_EN
  byte_demux8_rb_mux #(
    .DW (DW)
  ) u_rb_mux (
    .lanes   (o_bus),
    .sel     (rb_sel),
    .rb_data (rb_data)
  );
`endif

endmodule

// File: tb/tb_byte_demux8_reg.sv
// Self-checking bench for byte_demux8_reg: directed scenarios followed by random
// traffic, checked by a per-cycle scoreboard fed from a lane-array reference model.
// Define BYTE_DEMUX8_READBACK_EN to also exercise the rb_sel/rb_data readback port.
module tb_byte_demux8_reg;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [63:0] o_bus;
  logic [2:0]  wr_ptr;
  logic        frame_done;
`ifdef BYTE_DEMUX8_READBACK_EN
  logic [2:0]  rb_sel;
  logic [7:0]  rb_data;
`endif

  int checks = 0;
  int errors = 0;

  byte_demux8_reg_if #(.DW(8)) s_if ();

  byte_demux8_reg #(.DW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src         (s_if.slave),
    .frame_start (frame_start),
    .o_bus       (o_bus),
    .wr_ptr      (wr_ptr),
    .frame_done  (frame_done)
`ifdef BYTE_DEMUX8_READBACK_EN
    ,
    .rb_sel      (rb_sel),
    .rb_data     (rb_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] bus;
    logic [2:0]  ptr;
    logic        fd;
  } snap_t;

  snap_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: eight byte lanes, an integer pointer and a "frame just completed" flag.
  initial begin
    byte unsigned m_lane [8];
    int           m_ptr;
    bit           m_done;
    snap_t        s;
    foreach (m_lane[k]) m_lane[k] = 8'h00;
    m_ptr  = 0;
    m_done = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        foreach (m_lane[k]) m_lane[k] = 8'h00;
        m_ptr  = 0;
        m_done = 1'b0;
      end else if (frame_start) begin
        m_ptr  = 0;
        m_done = 1'b0;
      end else if (m_done) begin
        m_ptr  = 0;
        m_done = 1'b0;
      end else if (s_if.in_valid) begin
        if (s_if.in_addr_en) begin
          m_lane[s_if.in_addr] = s_if.in_data;
        end else begin
          m_lane[m_ptr] = s_if.in_data;
          if (m_ptr == 7) begin
            m_ptr  = 0;
            m_done = 1'b1;
          end else begin
            m_ptr = m_ptr + 1;
          end
        end
      end
      for (int k = 0; k < 8; k++) s.bus[8*k +: 8] = m_lane[k];
      s.ptr = 3'(m_ptr);
      s.fd  = m_done;
      exp_q.push_back(s);
    end
  end

  // Monitor: one scoreboard entry per clock, compared away from the active edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!rst_n) e = '0;
        chk("mon_o_bus", o_bus, e.bus);
        chk("mon_wr_ptr", 64'(wr_ptr), 64'(e.ptr));
        chk("mon_frame_done", 64'(frame_done), 64'(e.fd));
        chk("mon_in_ready", 64'(s_if.in_ready), 64'(rst_n && !e.fd && !frame_start));
`ifdef BYTE_DEMUX8_READBACK_EN
        chk("mon_rb_data", 64'(rb_data), 64'(e.bus[8*rb_sel +: 8]));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic v, input logic [7:0] d, input logic ae,
                      input logic [2:0] a, input logic fs);
    s_if.in_valid   = v;
    s_if.in_data    = d;
    s_if.in_addr_en = ae;
    s_if.in_addr    = a;
    frame_start     = fs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    frame_start     = 1'b0;
    s_if.in_valid   = 1'b0;
    s_if.in_data    = 8'h00;
    s_if.in_addr_en = 1'b0;
    s_if.in_addr    = 3'd0;
`ifdef BYTE_DEMUX8_READBACK_EN
    rb_sel = 3'd0;
`endif
    #1;
    chk("rst_in_ready", 64'(s_if.in_ready), 64'd0);
    chk("rst_o_bus", o_bus, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("idle_in_ready", 64'(s_if.in_ready), 64'd1);

    // Full auto frame 0x11..0x88; in_valid stays high into the DONE cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 8'((i + 1) * 17), 1'b0, 3'd0, 1'b0);
    chk("frame_o_bus", o_bus, 64'h8877665544332211);
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("done_in_ready", 64'(s_if.in_ready), 64'd0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("after_done_fd", 64'(frame_done), 64'd0);
    chk("after_done_ptr", 64'(wr_ptr), 64'd0);
    chk("after_done_bus", o_bus, 64'h8877665544332211);

`ifdef BYTE_DEMUX8_READBACK_EN
    for (int s = 0; s < 8; s++) begin
      rb_sel = 3'(s);
      #1 chk("rb_sweep", 64'(rb_data), 64'((s + 1) * 17));
    end
`endif

    // Explicit write at lane 5 with wr_ptr=2.
    step(1'b1, 8'hC0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 3'd5, 1'b0);
    chk("explicit_ptr", 64'(wr_ptr), 64'd2);
    chk("explicit_bus", o_bus, 64'h8877A5554433C1C0);
    chk("explicit_fd", 64'(frame_done), 64'd0);

    // Third auto write, then frame_start with in_valid high.
    step(1'b1, 8'hD2, 1'b0, 3'd0, 1'b0);
    s_if.in_data = 8'hEE;
    frame_start  = 1'b1;
    #1 chk("restart_in_ready", 64'(s_if.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("restart_ptr", 64'(wr_ptr), 64'd0);
    chk("restart_bus", o_bus, 64'h8877A55544D2C1C0);
    step(1'b1, 8'h5A, 1'b0, 3'd0, 1'b0);
    chk("restart_lane0", o_bus, 64'h8877A55544D2C15A);
    chk("restart_ptr1", 64'(wr_ptr), 64'd1);

    // Frame with in_valid held through DONE.
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0, 3'd0, 1'b0);
    chk("hold_fd", 64'(frame_done), 64'd1);
    step(1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
    chk("hold_no_write", o_bus, 64'h0807060504030201);
    chk("hold_ptr", 64'(wr_ptr), 64'd0);
    step(1'b1, 8'h09, 1'b0, 3'd0, 1'b0);
    chk("hold_next_lane0", o_bus, 64'h0807060504030209);
    chk("hold_next_ptr", 64'(wr_ptr), 64'd1);

    // Asynchronous reset between edges, mid-frame.
    step(1'b1, 8'h31, 1'b0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_o_bus", o_bus, 64'd0);
    chk("async_ptr", 64'(wr_ptr), 64'd0);
    chk("async_fd", 64'(frame_done), 64'd0);
    chk("async_in_ready", 64'(s_if.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_in_ready", 64'(s_if.in_ready), 64'd0);
    rst_n = 1'b1;

    // Random traffic checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
`ifdef BYTE_DEMUX8_READBACK_EN
      rb_sel = 3'($urandom_range(0, 7));
`endif
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
